// File: rtl/conv_sa_psum_drain_pkg.sv
// conv_sa_psum_drain_pkg: shared types for the psum drain slice
package conv_sa_psum_drain_pkg;
    typedef enum logic {IDLE, COLLECT} state_t;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/conv_sa_drain_fifo.sv
// conv_sa_drain_fifo: two-entry frame buffer, push honoured when full only alongside a pop
module conv_sa_drain_fifo
    import conv_sa_psum_drain_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         valid,
    output logic         full,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [FIFO_DEPTH];
    logic wp, rp, do_push, do_pop;
    logic [1:0] cnt;
    always_comb begin
        valid = cnt != 2'd0;
        full = cnt == 2'(FIFO_DEPTH);
        do_pop = pop && valid;
        do_push = push && (!full || do_pop);
        rdata = mem[rp];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= 1'b0;
            rp <= 1'b0;
            cnt <= 2'd0;
            mem <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp <= ~wp;
            end
            if (do_pop) rp <= ~rp;
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/incl.vh
// incl.vh: shared systolic-array geometry constants
`ifndef INCL_VH
`define INCL_VH
`define ROWS 4
`define P 4
`define PW 19
`define AW 8
`define WW 8
`endif

// File: rtl/conv_sa_psum_drain.sv
// conv_sa_psum_drain: deskews bottom-row psum columns into whole frames and buffers them
`include "incl.vh"
module conv_sa_psum_drain
    import conv_sa_psum_drain_pkg::*;
#(
    parameter int P  = `P,
    parameter int PW = `PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [P*PW-1:0] in_psum1,
    input  logic [P*PW-1:0] in_psum2,
    input  logic [P-1:0]  in_flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [P*PW-1:0] out_psum1,
    output logic [P*PW-1:0] out_psum2,
    output logic          err_skew,
    output logic          err_ovf
);
    localparam int W = P * PW;
    localparam int CW = P > 1 ? $clog2(P) : 1;
    localparam logic [CW-1:0] LAST = CW'(P - 1);
    state_t state;
    logic [CW-1:0] col;
    logic [W-1:0] stage1, stage2, frame1, frame2;
    logic [P-1:0] want;
    logic col_ok, restart, done, push, full, ovf;
    always_comb begin
        want = P'(1) << col;
        col_ok = in_flush == want;
        // last column of one frame may coincide with column 0 of the next
        restart = P > 1 && state == COLLECT && col == LAST && in_flush == (want | P'(1));
        done = (col_ok && col == LAST) || restart;
        push = done && !rst;
        ovf = push && full && !out_ready;
        frame1 = stage1;
        frame2 = stage2;
        frame1[(P-1)*PW +: PW] = in_psum1[(P-1)*PW +: PW];
        frame2[(P-1)*PW +: PW] = in_psum2[(P-1)*PW +: PW];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            col <= '0;
            stage1 <= '0;
            stage2 <= '0;
            err_skew <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (ovf) err_ovf <= 1'b1;
            if (restart) begin
                stage1 <= W'(in_psum1[PW-1:0]);
                stage2 <= W'(in_psum2[PW-1:0]);
                col <= CW'(1);
                state <= COLLECT;
            end else if (col_ok) begin
                if (col == '0) begin
                    stage1 <= W'(in_psum1[PW-1:0]);
                    stage2 <= W'(in_psum2[PW-1:0]);
                end else begin
                    stage1[col*PW +: PW] <= in_psum1[col*PW +: PW];
                    stage2[col*PW +: PW] <= in_psum2[col*PW +: PW];
                end
                col <= done ? '0 : col + CW'(1);
                state <= done ? IDLE : COLLECT;
            end else if (in_flush != '0 || state == COLLECT) begin
                err_skew <= 1'b1;
                col <= '0;
                state <= IDLE;
            end
        end
    end
    conv_sa_drain_fifo #(.W(2 * W)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata({frame2, frame1}),
        .pop  (out_valid && out_ready),
        .valid(out_valid),
        .full (full),
        .rdata({out_psum2, out_psum1})
    );
endmodule

// File: doc/conv_sa_psum_drain.md
CONV_SA_PSUM_DRAIN -- requirements
Module: conv_sa_psum_drain

Interface
REQ-001 SHALL have parameter P, default `P, meaning the number of PE columns in the systolic array.
REQ-002 SHALL have parameter PW, default 19, meaning the psum width per lane.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_psum1, input, P*PW bits: bottom-row psum lane 1; column i is at [i*PW+:PW].
REQ-006 SHALL have port in_psum2, input, P*PW bits: bottom-row psum lane 2; same packing as in_psum1.
REQ-007 SHALL have port in_flush, input, P bits: per-column flush strobe, skewed one cycle per column.
REQ-008 SHALL have port out_valid, output, 1 bit: a frame is presented on out_psum1/out_psum2.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the frame.
REQ-010 SHALL have port out_psum1, output, P*PW bits: deskewed lane-1 frame.
REQ-011 SHALL have port out_psum2, output, P*PW bits: deskewed lane-2 frame.
REQ-012 SHALL have port err_skew, output, 1 bit: sticky flush-wavefront violation flag.
REQ-013 SHALL have port err_ovf, output, 1 bit: sticky dropped-frame flag.

Function
REQ-014 SHALL have states IDLE and COLLECT, plus a column counter col in the range 0..P-1.
REQ-015 IDLE: in_flush[0]=1 SHALL capture column 0 of both lanes, set col=1, and go to COLLECT (if P=1, the frame completes immediately).
REQ-016 IDLE: in_flush bits other than bit 0 asserted SHALL set err_skew and leave the state in IDLE.
REQ-017 COLLECT: in_flush[col]=1 SHALL capture column col of both lanes into its staging register, then increment col.
REQ-018 COLLECT: a cycle where in_flush[col]=0, or any bit other than col is set, SHALL set err_skew, discard the partial frame, and go to IDLE; the exception is REQ-020.
REQ-019 Capturing column P-1 SHALL complete the frame, and the completed frame SHALL be pushed into the output buffer in the same cycle.
REQ-020 When in_flush[0] and in_flush[P-1] are both asserted in the cycle col=P-1, the block SHALL complete the old frame and start a new frame with col=1, with no error.
REQ-021 The output buffer SHALL hold 2 entries, FIFO order; out_valid SHALL be 1 whenever the buffer is not empty.
REQ-022 Latency SHALL be one cycle: out_valid rises the cycle after column P-1 is captured, provided the buffer was empty.
REQ-023 While out_valid=1 and out_ready=0, out_psum1 and out_psum2 SHALL hold stable.
REQ-024 A pop SHALL occur on out_valid&&out_ready.
REQ-025 A push and a pop in the same cycle SHALL both take effect when the buffer is full.
REQ-026 A frame completing while the buffer is full with no pop SHALL be dropped and SHALL set err_ovf; buffer contents are unchanged.
REQ-027 err_skew and err_ovf SHALL clear only on rst.
REQ-028 Staging registers SHALL be cleared to zero on every frame start.
REQ-029 Output data SHALL be copied bit-exact, with no arithmetic or sign change.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL go to IDLE with col=0 and the buffer empty.
REQ-031 On rst=1 at a clock edge, out_valid, err_skew, err_ovf, out_psum1 and out_psum2 SHALL all be 0.
REQ-032 rst mid-COLLECT SHALL discard the partial frame, and no frame SHALL be emitted for it.
REQ-033 in_flush SHALL be ignored in any cycle where rst=1.

Structure
REQ-034 P and PW SHALL come from the shared include incl.vh, alongside the existing array constants; no local redefinition.
REQ-035 The 2-entry buffer SHALL be one sub-module, conv_sa_drain_fifo, parameterized by data width 2*P*PW.
REQ-036 Deskew staging, the FSM and the error flags SHALL live in the top module.

Verification (bench P=4, PW=19)
REQ-037 Clean frame, out_ready=1:
- stimulus: in_flush[i] at cycle t+i, with column i psum1=i+1 and psum2=-(i+1);
- required response: out_valid at t+4, psum1 lanes {1,2,3,4}, psum2 lanes {-1,-2,-3,-4} (two's complement 19 bit); no errors.
REQ-038 Back-to-back frames:
- stimulus: second in_flush[0] at t+3 with first frame's in_flush[3];
- required response: two frames out at t+4 and t+7; err_skew=0.
REQ-039 Backpressure:
- stimulus: out_ready=0; three complete frames A, B, C;
- required response: A and B buffered; C dropped with err_ovf=1; out data holds A stable; raising out_ready yields A then B, never C.
REQ-040 Skew violation:
- stimulus: in_flush[0] at t, then in_flush[2] at t+1;
- required response: err_skew=1 at t+2, no out_valid, next clean frame emitted correctly.
REQ-041 Reset mid-collect:
- stimulus: rst at t+2 of a frame, then a clean frame;
- required response: only the clean frame emitted; all flags 0.
REQ-042 Full-buffer simultaneous push/pop:
- stimulus: buffer holds 2 entries, out_ready=1 in the completion cycle;
- required response: no drop; order preserved; err_ovf=0.
